// File: rtl/sim_memory_model_fifo_pkg.sv
// Shared parameter checks and the pointer-width helper
// for the simulation memory model FIFO.
package sim_memory_model_fifo_pkg;

  function automatic int ptr_width(input int d_n);
    return d_n + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int depth, input int d_n);
    return is_pow2(depth) && (d_n == $clog2(depth));
  endfunction

  function automatic bit th_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sim_memory_model_fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module sim_memory_model_fifo_ram #(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  parameter int D_N   = 4
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [D_N-1:0] waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [D_N-1:0] raddr_i,
  output logic [N-1:0] rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sim_memory_model_param_fifo.sv
// Parametrised FWFT FIFO with watermarks; sticky overflow/underflow
// detection enabled by SIM_MEMORY_MODEL_FIFO_ERROR_CHECK_EN.
module sim_memory_model_param_fifo
  import sim_memory_model_fifo_pkg::*;
#(
  parameter int N         = 16,
  parameter int DEPTH     = 16,
  parameter int D_N       = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic         iCLOCK,
  input  logic         inRESET,
  input  logic         iREMOVE,
  output logic [D_N:0] oCOUNT,
  input  logic         iWR_EN,
  input  logic [N-1:0] iWR_DATA,
  output logic         oWR_FULL,
  output logic         oWR_ALMOST_FULL,
  input  logic         iRD_EN,
  output logic [N-1:0] oRD_DATA,
  output logic         oRD_EMPTY,
  output logic         oRD_ALMOST_EMPTY,
  output logic         oOVERFLOW,
  output logic         oUNDERFLOW
);

  localparam int PTR_W = ptr_width(D_N);
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AEMPTY_TH);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  if (!depth_ok(DEPTH, D_N)) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two >= 2 with D_N == clog2(DEPTH)");
  end
  if (!th_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
    $fatal(1, "AFULL_TH or AEMPTY_TH out of range");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count;
  logic             push, pop;

  assign count            = wr_ptr_q - rd_ptr_q;
  assign oCOUNT           = count;
  assign oWR_FULL         = (count == DEPTH_C);
  assign oRD_EMPTY        = (count == '0);
  assign oWR_ALMOST_FULL  = (count >= AF_C);
  assign oRD_ALMOST_EMPTY = (count <= AE_C);

  // Requests are judged against this cycle's registered flags.
  assign push = iWR_EN && !oWR_FULL && !iREMOVE;
  assign pop  = iRD_EN && !oRD_EMPTY && !iREMOVE;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (iREMOVE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE_C;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_C;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sim_memory_model_fifo_ram #(
    .N     (N),
    .DEPTH (DEPTH),
    .D_N   (D_N)
  ) u_ram (
    .clk_i   (iCLOCK),
    .we_i    (push && inRESET),
    .waddr_i (wr_ptr_q[D_N-1:0]),
    .wdata_i (iWR_DATA),
    .raddr_i (rd_ptr_q[D_N-1:0]),
    .rdata_o (oRD_DATA)
  );

`ifdef SIM_MEMORY_MODEL_FIFO_ERROR_CHECK_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic ovf_ev, unf_ev;

  assign ovf_ev = iWR_EN && oWR_FULL && !iREMOVE;
  assign unf_ev = iRD_EN && oRD_EMPTY && !iREMOVE;

  always_comb begin
    ovf_d = ovf_q | ovf_ev;
    unf_d = unf_q | unf_ev;
    if (iREMOVE) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (ovf_ev)
        $error("%0t fifo overflow wr_ptr=%0d rd_ptr=%0d",
               $time, wr_ptr_q, rd_ptr_q);
      if (unf_ev)
        $error("%0t fifo underflow wr_ptr=%0d rd_ptr=%0d",
               $time, wr_ptr_q, rd_ptr_q);
    end
  end

  assign oOVERFLOW  = ovf_q;
  assign oUNDERFLOW = unf_q;
`else
  assign oOVERFLOW  = 1'b0;
  assign oUNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_sim_memory_model_param_fifo.sv
// Randomised and directed bench for sim_memory_model_param_fifo
// against a queue-based reference model.
module tb_sim_memory_model_param_fifo;

  localparam int N     = 16;
  localparam int DEPTH = 16;
  localparam int D_N   = 4;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic         clk;
  logic         rst_n;
  logic         rm;
  logic [D_N:0] count;
  logic         wr_en;
  logic [N-1:0] wr_data;
  logic         full, afull;
  logic         rd_en;
  logic [N-1:0] rd_data;
  logic         empty, aempty;
  logic         ovf, unf;

  sim_memory_model_param_fifo #(
    .N(N), .DEPTH(DEPTH), .D_N(D_N),
    .AFULL_TH(AF), .AEMPTY_TH(AE)
  ) dut (
    .iCLOCK           (clk),
    .inRESET          (rst_n),
    .iREMOVE          (rm),
    .oCOUNT           (count),
    .iWR_EN           (wr_en),
    .iWR_DATA         (wr_data),
    .oWR_FULL         (full),
    .oWR_ALMOST_FULL  (afull),
    .iRD_EN           (rd_en),
    .oRD_DATA         (rd_data),
    .oRD_EMPTY        (empty),
    .oRD_ALMOST_EMPTY (aempty),
    .oOVERFLOW        (ovf),
    .oUNDERFLOW       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] mq[$];
  bit m_ovf = 0;
  bit m_unf = 0;

`ifdef SIM_MEMORY_MODEL_FIFO_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    chk({tag, ".afull"}, 32'(afull), 32'(sz >= AF));
    chk({tag, ".aempty"}, 32'(aempty), 32'(sz <= AE));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(unf), 32'(m_unf));
    if (sz != 0) chk({tag, ".data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  task automatic cyc(input string tag, input bit r_n, input bit r,
                     input bit w, input logic [N-1:0] d, input bit rd);
    bit was_full, was_empty;
    rst_n   = r_n;
    rm      = r;
    wr_en   = w;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (!r_n) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (r) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (ERR_EN && w && was_full) m_ovf = 1;
      if (ERR_EN && rd && was_empty) m_unf = 1;
      if (rd && !was_empty) void'(mq.pop_front());
      if (w && !was_full) mq.push_back(d);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    int pw, pr;
    rst_n = 1'b0; rm = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

    cyc("reset", 0, 0, 0, 16'h0, 0);
    cyc("idle", 1, 0, 0, 16'h0, 0);

    for (int i = 0; i < 16; i++) cyc("fill", 1, 0, 1, 16'(i), 0);
    cyc("push_full", 1, 0, 1, 16'hDEAD, 0);
    for (int i = 0; i < 16; i++) cyc("drain", 1, 0, 0, 16'h0, 1);

    cyc("empty_pushpop", 1, 0, 1, 16'h1234, 1);
    cyc("pop1234", 1, 0, 0, 16'h0, 1);

    for (int i = 0; i < 8; i++) cyc("pre8", 1, 0, 1, 16'(16'h100 + i), 0);
    for (int i = 0; i < 40; i++)
      cyc("steady8", 1, 0, 1, 16'(16'h200 + i), 1);

    cyc("remove_a", 1, 1, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) cyc("pre5", 1, 0, 1, 16'(16'h300 + i), 0);
    cyc("remove_push", 1, 1, 1, 16'hBEEF, 0);
    cyc("after_remove", 1, 0, 0, 16'h0, 0);

    for (int i = 0; i < 7; i++) cyc("pre7", 1, 0, 1, 16'(16'h400 + i), 0);
    cyc("reset_push", 0, 0, 1, 16'hCAFE, 0);
    cyc("after_reset", 1, 0, 0, 16'h0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (((i / 150) % 2) == 0) begin pw = 80; pr = 35; end
      else begin pw = 35; pr = 80; end
      cyc("rand",
          ($urandom_range(0, 399) != 0),
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 99) < pw),
          16'($urandom),
          ($urandom_range(0, 99) < pr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sim_memory_model_param_fifo.md
# sim_memory_model_param_fifo

Parametrised synchronous FIFO for the simulation memory model, replacing the fixed-behaviour queue in request/response paths between the bus-side front end and the memory array model. It adds guarded push/pop, a full-range occupancy count, programmable almost-full/almost-empty watermarks and optional sticky overflow/underflow detection. Read data is first-word-fall-through: the head entry is always present on `oRD_DATA`.

## Interface
Parameters:
- `N`, 16, data width in bits.
- `DEPTH`, 16, entry count; must be a power of two, at least 2.
- `D_N`, 4, log2(DEPTH).
- `AFULL_TH`, 12, `oWR_ALMOST_FULL` asserts when count >= AFULL_TH; valid range 1..DEPTH.
- `AEMPTY_TH`, 2, `oRD_ALMOST_EMPTY` asserts when count <= AEMPTY_TH; valid range 0..DEPTH-1.

Ports:
- `iCLOCK` in 1: single clock, all logic on its rising edge.
- `inRESET` in 1: reset, synchronous, active-low.
- `iREMOVE` in 1: synchronous flush of all entries.
- `oCOUNT` out D_N+1: occupancy, 0..DEPTH.
- `iWR_EN` in 1: push request.
- `iWR_DATA` in N: push data.
- `oWR_FULL` out 1: count == DEPTH.
- `oWR_ALMOST_FULL` out 1: count >= AFULL_TH.
- `iRD_EN` in 1: pop request.
- `oRD_DATA` out N: head entry, FWFT.
- `oRD_EMPTY` out 1: count == 0.
- `oRD_ALMOST_EMPTY` out 1: count <= AEMPTY_TH.
- `oOVERFLOW` out 1: sticky, push attempted while full.
- `oUNDERFLOW` out 1: sticky, pop attempted while empty.

## Operation
- Write and read pointers are D_N+1 bits wide. The MSB is the wrap bit. The low D_N bits index storage. Count = wr_ptr − rd_ptr, modulo 2^(D_N+1).
- Push is accepted iff `iWR_EN` && !`oWR_FULL`. On accept, storage[wr_ptr[D_N-1:0]] <= `iWR_DATA` and wr_ptr increments.
- Pop is accepted iff `iRD_EN` && !`oRD_EMPTY`. On accept, rd_ptr increments.
- A push while full is dropped: no pointer or storage change. A pop while empty is ignored.
- Simultaneous push and pop:
  - Each request is judged against the flags of the current cycle.
  - When full, the pop is accepted and the push is dropped.
  - When empty, the push is accepted and the pop is ignored.
  - Otherwise both are accepted and the count is unchanged.
- `iREMOVE` zeroes both pointers and clears the sticky flags. It overrides any push or pop in the same cycle. Storage contents are not cleared.
- All flags and `oCOUNT` are decoded combinationally from the registered pointers and sticky bits. They are therefore glitch-free relative to inputs and never depend combinationally on `iWR_EN` or `iRD_EN`.
- `oRD_DATA` = storage[rd_ptr[D_N-1:0]]. It is undefined (don't-care) while empty.

## Timing
- Reset (`inRESET` low at a rising edge):
  - pointers = 0, so `oCOUNT`=0, `oRD_EMPTY`=1, `oWR_FULL`=0.
  - `oRD_ALMOST_EMPTY`=1, `oWR_ALMOST_FULL`=0.
  - `oOVERFLOW`=`oUNDERFLOW`=0.
- Reset mid-operation discards all entries on that edge.
- Reset takes priority over `iREMOVE`, which takes priority over push/pop.
- Write-to-read latency is 1 cycle. A push at edge k makes `oRD_EMPTY`=0 and the data visible on `oRD_DATA` after edge k.
- Pop latency is 1 cycle. After the accepting edge, `oRD_DATA` shows the next entry.
- A full FIFO reads DEPTH after DEPTH accepted pushes with no pops. Pointer wrap is seamless: after 2^(D_N+1) pushes, the pointers return to 0 with correct count.

## Configuration
- Macro: `SIM_MEMORY_MODEL_FIFO_ERROR_CHECK_EN`.
- Defined:
  - `oOVERFLOW` sets on any cycle with `iWR_EN` && `oWR_FULL` && !`iREMOVE`.
  - `oUNDERFLOW` sets on any cycle with `iRD_EN` && `oRD_EMPTY` && !`iREMOVE`.
  - Both stay set until reset or `iREMOVE`.
  - A simulation `$error` with time and pointer values is issued on each event.
- Undefined: both ports remain, tied to 0. No sticky registers and no messages.
- Drop/ignore behaviour of the data path is identical in both builds.

## Structure
- Package `sim_memory_model_fifo_pkg` holds:
  - elaboration-time check functions: power-of-two DEPTH, D_N == $clog2(DEPTH), threshold ranges;
  - the pointer-width localparam helper.
- Illegal parameters are a fatal elaboration error.
- Sub-module `sim_memory_model_fifo_ram`: N×DEPTH storage with 1 synchronous write port and 1 asynchronous read port. Pointer control and flags stay in the top module.

## Test plan
- Reset, then 16 pushes of 0x0000..0x000F (DEPTH=16) → `oCOUNT` ramps 1..16; `oWR_ALMOST_FULL` rises after the 12th push; `oWR_FULL`=1 after the 16th.
- Push 0xDEAD while full → entry dropped, `oCOUNT` stays 16, `oOVERFLOW`=1 (macro on) or 0 (macro off); pop 16 → data 0x0000..0x000F in order.
- Empty FIFO, push 0x1234 and assert `iRD_EN` in the same cycle → pop ignored; next cycle `oRD_DATA`=0x1234, `oCOUNT`=1; `oUNDERFLOW`=1 (macro on).
- Steady concurrent push/pop at count 8 for 40 cycles → count holds at 8 across pointer wrap; output sequence matches input sequence delayed by 8 entries.
- Count 5, then `iREMOVE` with simultaneous `iWR_EN` → `oCOUNT`=0, `oRD_EMPTY`=1, sticky flags cleared; push not stored.
- Count 7 with `inRESET` pulsed low for one edge while pushing → after that edge `oCOUNT`=0, `oRD_ALMOST_EMPTY`=1, all other outputs at reset values.
